// File: rtl/alien_bullet.sv
// Alien column projectile engine: periodic launch from the alien, fixed-rate
// downward motion, and bounding-box hit test against the player ship.
//
// state  | meaning
// IDLE   | no bullet in flight; fire_cnt paces launch attempts
// FLIGHT | bullet moving down; step_cnt paces moves, hit test every cycle
module alien_bullet #(
   parameter int ALIEN_W       = 16,
   parameter int ALIEN_H       = 12,
   parameter int BULLET_W      = 2,
   parameter int BULLET_H      = 4,
   parameter int PLAYER_W      = 20,
   parameter int PLAYER_H      = 10,
   parameter int STEP_TICKS    = 400000,
   parameter int SPEED         = 2,
   parameter int SCREEN_BOTTOM = 240
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        enable,
   input  logic [9:0]  alienX,
   input  logic [8:0]  alienY,
   input  logic        frontalive,
   input  logic [27:0] firefreq,
   input  logic [9:0]  playerX,
   input  logic [8:0]  playerY,
   output logic [9:0]  bulletX,
   output logic [8:0]  bulletY,
   output logic        bullet_active,
   output logic        fire,
   output logic        hit
);

   localparam int STEP_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS - 1);
   localparam logic [9:0] LAUNCH_DX = 10'(ALIEN_W / 2 - BULLET_W / 2);
   localparam logic [8:0] LAUNCH_DY = 9'(ALIEN_H);

   typedef enum logic {IDLE, FLIGHT} state_t;

   state_t            state;
   logic [27:0]       fire_cnt;
   logic [STEP_W-1:0] step_cnt;

   logic [10:0] bx, by, px, py;
   logic [10:0] next_y;
   logic        overlap;
   logic        off_bottom;
   logic        fire_last;

   // 11-bit sums so box edges near the right/bottom of the screen never wrap
   assign bx = {1'b0, bulletX};
   assign by = {2'b0, bulletY};
   assign px = {1'b0, playerX};
   assign py = {2'b0, playerY};

   assign overlap = (bx < px + 11'(PLAYER_W)) &&
                    (bx + 11'(BULLET_W) > px) &&
                    (by < py + 11'(PLAYER_H)) &&
                    (by + 11'(BULLET_H) > py);

   assign next_y     = by + 11'(SPEED);
   assign off_bottom = next_y >= 11'(SCREEN_BOTTOM);
   assign fire_last  = fire_cnt == (firefreq - 28'd1);

   always_ff @(posedge clk) begin
      if (resetn) begin
         state         <= IDLE;
         fire_cnt      <= '0;
         step_cnt      <= '0;
         bulletX       <= '0;
         bulletY       <= '0;
         bullet_active <= 1'b0;
         fire          <= 1'b0;
         hit           <= 1'b0;
      end else begin
         fire <= 1'b0;
         hit  <= 1'b0;
         if (enable) begin
            case (state)
               IDLE: begin
                  if (firefreq == 28'd0) begin
                     fire_cnt <= '0;
                  end else if (fire_last) begin
                     fire_cnt <= '0;
                     // a dead or non-front alien simply forfeits this attempt
                     if (frontalive) begin
                        bulletX       <= alienX + LAUNCH_DX;
                        bulletY       <= alienY + LAUNCH_DY;
                        step_cnt      <= '0;
                        bullet_active <= 1'b1;
                        fire          <= 1'b1;
                        state         <= FLIGHT;
                     end
                  end else begin
                     fire_cnt <= fire_cnt + 28'd1;
                  end
               end
               FLIGHT: begin
                  if (overlap) begin
                     hit           <= 1'b1;
                     bullet_active <= 1'b0;
                     fire_cnt      <= '0;
                     state         <= IDLE;
                  end else if (step_cnt == STEP_LAST) begin
                     step_cnt <= '0;
                     if (off_bottom) begin
                        bullet_active <= 1'b0;
                        fire_cnt      <= '0;
                        state         <= IDLE;
                     end else begin
                        bulletY <= next_y[8:0];
                     end
                  end else begin
                     step_cnt <= step_cnt + STEP_W'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alien_bullet.sv
// Directed bench for alien_bullet with a short step period: launch, motion,
// hit, bottom retire, dropped attempts, freeze, and mid-flight reset.
module tb_alien_bullet;

   logic        clk = 1'b0;
   logic        resetn;
   logic        enable;
   logic [9:0]  alienX;
   logic [8:0]  alienY;
   logic        frontalive;
   logic [27:0] firefreq;
   logic [9:0]  playerX;
   logic [8:0]  playerY;
   logic [9:0]  bulletX;
   logic [8:0]  bulletY;
   logic        bullet_active;
   logic        fire;
   logic        hit;

   int vectors = 0;
   int errors  = 0;
   int nfire;

   always #5 clk = ~clk;

   alien_bullet #(.STEP_TICKS(4)) dut (
      .clk(clk), .resetn(resetn), .enable(enable),
      .alienX(alienX), .alienY(alienY), .frontalive(frontalive),
      .firefreq(firefreq), .playerX(playerX), .playerY(playerY),
      .bulletX(bulletX), .bulletY(bulletY), .bullet_active(bullet_active),
      .fire(fire), .hit(hit)
   );

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      resetn = 1'b1; enable = 1'b1;
      alienX = 10'd100; alienY = 9'd50; frontalive = 1'b1; firefreq = 28'd10;
      playerX = 10'd100; playerY = 9'd80;
      cyc(3);
      chk("rst_bx", bulletX, 0);
      chk("rst_by", bulletY, 0);
      chk("rst_act", bullet_active, 0);
      chk("rst_fire", fire, 0);
      chk("rst_hit", hit, 0);

      // launch 10 edges after release
      resetn = 1'b0;
      cyc(9);
      chk("prefire", fire, 0);
      cyc(1);
      chk("fire1", fire, 1);
      chk("launch_bx", bulletX, 107);
      chk("launch_by", bulletY, 62);
      chk("launch_act", bullet_active, 1);
      alienX = 10'd300;
      cyc(1);
      chk("fire_pulse", fire, 0);
      chk("hold_by", bulletY, 62);
      chk("fixed_bx", bulletX, 107);
      cyc(3);
      chk("step1_by", bulletY, 64);
      cyc(24);
      chk("by76", bulletY, 76);
      chk("nohit76", hit, 0);
      cyc(4);
      chk("by78", bulletY, 78);
      chk("nohit78", hit, 0);
      chk("act78", bullet_active, 1);
      cyc(1);
      chk("hit", hit, 1);
      chk("hit_act", bullet_active, 0);
      chk("hit_by", bulletY, 78);
      cyc(1);
      chk("hit_pulse", hit, 0);
      cyc(8);
      chk("refire_early", fire, 0);
      cyc(1);
      chk("refire", fire, 1);
      chk("refire_bx", bulletX, 307);
      chk("refire_by", bulletY, 62);

      // freeze mid-flight with two ticks already spent
      cyc(2);
      enable = 1'b0;
      cyc(7);
      chk("frz_by", bulletY, 62);
      chk("frz_act", bullet_active, 1);
      enable = 1'b1;
      cyc(1);
      chk("resume_by", bulletY, 62);
      cyc(1);
      chk("resume_step", bulletY, 64);

      // reset in the same cycle an overlap appears: no hit pulse
      playerX = 10'd300; playerY = 9'd60;
      resetn = 1'b1;
      cyc(1);
      chk("mrst_bx", bulletX, 0);
      chk("mrst_by", bulletY, 0);
      chk("mrst_act", bullet_active, 0);
      chk("mrst_hit", hit, 0);
      chk("mrst_fire", fire, 0);

      // bottom retire
      playerX = 10'd0; playerY = 9'd0; alienX = 10'd100; alienY = 9'd220;
      resetn = 1'b0;
      cyc(10);
      chk("ret_fire", fire, 1);
      chk("ret_by0", bulletY, 232);
      cyc(4);
      chk("ret_by1", bulletY, 234);
      cyc(4);
      chk("ret_by2", bulletY, 236);
      cyc(4);
      chk("ret_by3", bulletY, 238);
      cyc(3);
      chk("ret_act_pre", bullet_active, 1);
      cyc(1);
      chk("ret_act", bullet_active, 0);
      chk("ret_hit", hit, 0);
      chk("ret_by_hold", bulletY, 238);

      // dropped attempt, then counter restarts
      frontalive = 1'b0;
      cyc(10);
      chk("drop_fire", fire, 0);
      chk("drop_act", bullet_active, 0);
      frontalive = 1'b1;
      cyc(9);
      chk("drop_restart_early", fire, 0);
      cyc(1);
      chk("drop_restart", fire, 1);
      chk("drop_restart_by", bulletY, 232);

      // firefreq 0 never fires
      resetn = 1'b1;
      cyc(1);
      resetn = 1'b0;
      firefreq = 28'd0;
      nfire = 0;
      for (int i = 0; i < 1000; i++) begin
         cyc(1);
         if (fire) nfire++;
      end
      chk("ff0_fires", nfire, 0);
      chk("ff0_act", bullet_active, 0);
      firefreq = 28'd3;
      cyc(2);
      chk("ff3_early", fire, 0);
      cyc(1);
      chk("ff3_fire", fire, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
